output_serializer: RTL and testbench

OUTPUT_SERIALIZER -- requirements
Module: output_serializer

---
 rtl/output_serializer.sv | 99 +++++++++
 tb/tb_output_serializer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_serializer.sv
// Streams a captured 4x4 matrix out one element per accepted transfer over a
// valid/ready handshake, with a one-cycle done pulse after the final element.
module output_serializer #(
  parameter int ELEM_W = 16,
  parameter int N_ELEM = 16,
  localparam int BUS_W = ELEM_W * N_ELEM,
  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [BUS_W-1:0]  matrix_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ELEM_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [BUS_W-1:0] shadow;

  function automatic logic [ELEM_W-1:0] elem_at(input logic [BUS_W-1:0] m,
                                                input logic [IDX_W-1:0] k);
    return m[int'(k)*ELEM_W +: ELEM_W];
  endfunction

  always_comb begin
    idx_next = idx + IDX_W'(1);
  end

  // Every output is a flop; next values are computed from state and the
  // shadow copy so load/out_ready never reach an output combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      shadow    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shadow <= matrix_in;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          idx       <= '0;
          out_valid <= 1'b1;
          out_data  <= elem_at(shadow, '0);
          out_index <= '0;
          out_last  <= (N_ELEM == 1);
          state     <= SEND;
        end
        SEND: begin
          // out_valid is always high here, so out_ready alone marks a transfer
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              idx       <= idx_next;
              out_data  <= elem_at(shadow, idx_next);
              out_index <= idx_next;
              out_last  <= (idx_next == LAST_IDX);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_serializer.sv
// Scoreboard bench for output_serializer: stimulus pushes expected elements,
// a negedge monitor pops and compares on every handshake.
module tb_output_serializer;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [255:0] matrix_in = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [15:0]  out_data;
  logic [3:0]   out_index;
  logic         out_last;
  logic         busy;
  logic         done;

  output_serializer #(.ELEM_W(16), .N_ELEM(16)) dut (
    .clk(clk), .reset(reset), .load(load), .matrix_in(matrix_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] make_mat(input logic [15:0] base, input logic [15:0] step);
    logic [255:0] m;
    m = '0;
    for (int k = 0; k < 16; k++) m[k*16 +: 16] = base + 16'(k) * step;
    return m;
  endfunction

  task automatic push_stream(input logic [15:0] base, input logic [15:0] step);
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      e.data = base + 16'(k) * step;
      e.idx  = 4'(k);
      e.last = (k == 15);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_index(input logic [3:0] k);
    int i;
    i = 0;
    while (!(out_valid && out_index == k) && i < 100) begin
      tick();
      i++;
    end
    chk("wait_index", {63'd0, (out_valid && out_index == k)}, 64'd1);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 300) begin
      tick();
      i++;
    end
    chk("wait_idle", {63'd0, busy}, 64'd0);
  endtask

  // Monitor: handshake scoreboard, stall stability, done timing
  logic        prev_stall = 1'b0;
  logic        prev_last_xfer = 1'b0;
  logic [20:0] held = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_stall     = 1'b0;
      prev_last_xfer = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_hold", {43'd0, out_data, out_index, out_last}, {43'd0, held});
      end
      if (prev_last_xfer) begin
        chk("done_after_last", {63'd0, done}, 64'd1);
        chk("valid_after_last", {63'd0, out_valid}, 64'd0);
      end else if (done) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: done=1 without preceding last transfer at %0t", $time);
      end
      if (done) done_seen++;
      prev_last_xfer = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: data %0h index %0d with empty scoreboard", out_data, out_index);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_data", {48'd0, out_data}, {48'd0, e.data});
          chk("xfer_index", {60'd0, out_index}, {60'd0, e.idx});
          chk("xfer_last", {63'd0, out_last}, {63'd0, e.last});
          prev_last_xfer = e.last;
        end
      end
      prev_stall = out_valid && !out_ready;
      held = {out_data, out_index, out_last};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int d0;
    logic [3:0] pat;
    pat = 4'b1001;

    // Reset state
    #12;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", {48'd0, out_data}, 64'd0);
    chk("rst_index", {60'd0, out_index}, 64'd0);
    chk("rst_last", {63'd0, out_last}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("idle_valid", {63'd0, out_valid}, 64'd0);

    // Basic stream with latency and busy length
    matrix_in = make_mat(16'h1000, 16'h0001);
    out_ready = 1'b1;
    d0 = done_seen;
    push_stream(16'h1000, 16'h0001);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("lat_valid_lo", {63'd0, out_valid}, 64'd0);
    chk("lat_busy", {63'd0, busy}, 64'd1);
    cnt = 1;
    tick();
    chk("lat_valid_hi", {63'd0, out_valid}, 64'd1);
    chk("lat_index0", {60'd0, out_index}, 64'd0);
    if (busy) cnt++;
    for (int i = 0; i < 100 && busy; i++) begin
      tick();
      if (busy) cnt++;
    end
    chk("busy_cycles", 64'(cnt), 64'd18);
    chk("done_count1", 64'(done_seen - d0), 64'd1);

    // Backpressure with ready pattern 1,0,0,1
    tick();
    matrix_in = make_mat(16'h2000, 16'h0003);
    d0 = done_seen;
    push_stream(16'h2000, 16'h0003);
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 0; c < 300 && busy; c++) begin
      out_ready = pat[c % 4];
      tick();
    end
    chk("stall_idle", {63'd0, busy}, 64'd0);
    chk("done_count2", 64'(done_seen - d0), 64'd1);
    chk("stall_drained", 64'(exp_q.size()), 64'd0);
    out_ready = 1'b1;

    // Load while busy is ignored; later load streams the second matrix
    tick();
    matrix_in = make_mat(16'h3000, 16'h0001);
    d0 = done_seen;
    push_stream(16'h3000, 16'h0001);
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_index(4'd5);
    matrix_in = make_mat(16'h4000, 16'h0010);
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_idle();
    chk("done_count3", 64'(done_seen - d0), 64'd1);
    push_stream(16'h4000, 16'h0010);
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_idle();
    chk("done_count4", 64'(done_seen - d0), 64'd2);

    // matrix_in changes right after capture
    tick();
    matrix_in = make_mat(16'h5000, 16'h0101);
    push_stream(16'h5000, 16'h0101);
    load = 1'b1;
    tick();
    load = 1'b0;
    matrix_in = {256{1'b1}};
    wait_idle();

    // Asynchronous reset during element 9
    tick();
    matrix_in = make_mat(16'h6000, 16'h0001);
    d0 = done_seen;
    push_stream(16'h6000, 16'h0001);
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_index(4'd9);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_data", {48'd0, out_data}, 64'd0);
    chk("arst_index", {60'd0, out_index}, 64'd0);
    chk("arst_last", {63'd0, out_last}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    exp_q.delete();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("post_rst_idle", {63'd0, busy}, 64'd0);
    chk("no_done_on_abort", 64'(done_seen - d0), 64'd0);
    matrix_in = make_mat(16'h7000, 16'h0002);
    push_stream(16'h7000, 16'h0002);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("restart_busy", {63'd0, busy}, 64'd1);
    wait_idle();
    chk("done_count5", 64'(done_seen - d0), 64'd1);

    // Long stall at the last element
    tick();
    matrix_in = make_mat(16'h8000, 16'h0001);
    d0 = done_seen;
    push_stream(16'h8000, 16'h0001);
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_index(4'd15);
    out_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("hold15_valid", {63'd0, out_valid}, 64'd1);
      chk("hold15_last", {63'd0, out_last}, 64'd1);
      chk("hold15_data", {48'd0, out_data}, 64'h800F);
    end
    chk("no_early_done", 64'(done_seen - d0), 64'd0);
    out_ready = 1'b1;
    wait_idle();
    chk("done_count6", 64'(done_seen - d0), 64'd1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
